// File: rtl/clz_clo_iter_unit.sv
// Iterative count-leading-zeros / count-leading-ones unit.
// A binary search resolves one result bit per cycle, MSB first, so the
// latency is clog2(WIDTH)+1 cycles from start to done for every operand.
// CLO reuses the CLZ datapath by inverting the operand when it is latched.
module clz_clo_iter_unit #(
    parameter int WIDTH    = 32,
    parameter int RESULT_W = 32
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                start,
    input  logic                mode_clo,
    input  logic [WIDTH-1:0]    operand,
    input  logic                flush,
    output logic                busy,
    output logic                done,
    output logic [RESULT_W-1:0] result
);

    localparam int L = $clog2(WIDTH);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state;
    logic [WIDTH-1:0] work;      // operand, shifted left as leading zeros are consumed
    logic [L-1:0]     step;      // index of the result bit resolved this cycle
    logic [L-1:0]     res;       // result bits resolved so far
    logic             zflag;     // whole (possibly inverted) operand is zero

    logic [L:0]       h;         // window width 2^step
    logic [WIDTH-1:0] top_mask;  // selects the top h bits of work
    logic             bit_set;   // top window is all zeros
    logic [L-1:0]     res_next;
    logic [WIDTH-1:0] latch_work;

    // Search step: test whether the top 2^step bits are all zero.
    always_comb begin
        // NOTE: every signal gets a default before any partial update, so no latch is inferred.
        h           = {{L{1'b0}}, 1'b1} << step;
        top_mask    = ~({WIDTH{1'b1}} >> h);
        bit_set     = ((work & top_mask) == '0);
        res_next    = res;
        res_next[step] = bit_set;
        latch_work  = mode_clo ? ~operand : operand;
    end

    // Control FSM with registered busy/done/result.
    // NOTE: all state here uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= IDLE;
            work   <= '0;
            step   <= '0;
            res    <= '0;
            zflag  <= 1'b0;
            busy   <= 1'b0;
            done   <= 1'b0;
            result <= '0;
        end else begin
            done <= 1'b0;
            if (flush) begin
                // Cancel wins over everything; result keeps its last value.
                state <= IDLE;
                busy  <= 1'b0;
            end else begin
                case (state)
                    IDLE: begin
                        if (start) begin
                            work  <= latch_work;
                            zflag <= (latch_work == '0);
                            step  <= L'(L - 1);
                            res   <= '0;
                            state <= CALC;
                            busy  <= 1'b1;
                        end
                    end
                    CALC: begin
                        res <= res_next;
                        if (bit_set) begin
                            work <= work << h;
                        end
                        if (step == '0) begin
                            state  <= DONE;
                            done   <= 1'b1;
                            result <= zflag ? RESULT_W'(WIDTH) : RESULT_W'(res_next);
                        end else begin
                            step <= step - 1'b1;
                        end
                    end
                    DONE: begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end
                    default: begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_clz_clo_iter_unit.sv
// Self-checking bench for clz_clo_iter_unit: a 32-bit and a 16-bit instance
// are compared every cycle against a cycle-count model whose results come
// from a plain bit-walking leading-count function.
module tb_clz_clo_iter_unit;

    localparam int LAT32 = 6;   // done cycle after start for WIDTH=32
    localparam int LAT16 = 5;   // done cycle after start for WIDTH=16

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n;
    logic        start32, mode32, flush32;
    logic [31:0] op32;
    logic        busy32, done32;
    logic [31:0] res32;
    logic        start16, mode16, flush16;
    logic [15:0] op16;
    logic        busy16, done16;
    logic [7:0]  res16;

    int checks = 0;
    int errors = 0;

    clz_clo_iter_unit #(.WIDTH(32), .RESULT_W(32)) dut32 (
        .clk(clk), .rst_n(rst_n), .start(start32), .mode_clo(mode32),
        .operand(op32), .flush(flush32), .busy(busy32), .done(done32), .result(res32)
    );

    clz_clo_iter_unit #(.WIDTH(16), .RESULT_W(8)) dut16 (
        .clk(clk), .rst_n(rst_n), .start(start16), .mode_clo(mode16),
        .operand(op16), .flush(flush16), .busy(busy16), .done(done16), .result(res16)
    );

    task automatic check(input string name, input logic [63:0] actual, input logic [63:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, actual, expected, $time);
        end
    endtask

    // Count leading bits equal to 'ones', walking down from the MSB.
    function automatic int lead_count(input logic [63:0] value, input bit ones, input int width);
        int n = 0;
        for (int i = width - 1; i >= 0; i--) begin
            if (value[i] != ones) break;
            n++;
        end
        return n;
    endfunction

    // Model: cnt = cycles the unit still stays busy; done in its last busy cycle.
    int          m32_cnt, m16_cnt;
    logic [63:0] m32_pend, m32_res, m16_pend, m16_res;
    int          ops32 = 0;
    int          ops16 = 0;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m32_cnt <= 0;
            m32_res <= 0;
        end else if (flush32) begin
            m32_cnt <= 0;
        end else if (m32_cnt == 0) begin
            if (start32) begin
                m32_cnt  <= LAT32;
                m32_pend <= 64'(lead_count(64'(op32), mode32, 32));
                ops32    <= ops32 + 1;
            end
        end else begin
            m32_cnt <= m32_cnt - 1;
            if (m32_cnt == 2) m32_res <= m32_pend;
        end
    end

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m16_cnt <= 0;
            m16_res <= 0;
        end else if (flush16) begin
            m16_cnt <= 0;
        end else if (m16_cnt == 0) begin
            if (start16) begin
                m16_cnt  <= LAT16;
                m16_pend <= 64'(lead_count(64'(op16), mode16, 16));
                ops16    <= ops16 + 1;
            end
        end else begin
            m16_cnt <= m16_cnt - 1;
            if (m16_cnt == 2) m16_res <= m16_pend;
        end
    end

    // Compare process: every cycle out of reset, both instances.
    always @(negedge clk) begin
        if (rst_n === 1'b1) begin
            check("busy32", 64'(busy32), 64'(m32_cnt > 0));
            check("done32", 64'(done32), 64'(m32_cnt == 1));
            check("result32", 64'(res32), m32_res);
            check("busy16", 64'(busy16), 64'(m16_cnt > 0));
            check("done16", 64'(done16), 64'(m16_cnt == 1));
            check("result16", 64'(res16), m16_res);
        end
    end

    task automatic run32(input logic [31:0] op, input bit clo, input int expv, input string name);
        int cyc;
        check({name, " model"}, 64'(lead_count(64'(op), clo, 32)), 64'(expv));
        @(negedge clk);
        start32 = 1'b1; op32 = op; mode32 = clo;
        @(negedge clk);
        start32 = 1'b0; op32 = $urandom; mode32 = 1'($urandom);
        cyc = 1;
        while (!done32 && cyc < 20) begin
            @(negedge clk);
            cyc++;
        end
        check({name, " latency"}, 64'(cyc), 64'(LAT32));
        check({name, " result"}, 64'(res32), 64'(expv));
    endtask

    task automatic run16(input logic [15:0] op, input bit clo, input int expv, input string name);
        int cyc;
        check({name, " model"}, 64'(lead_count(64'(op), clo, 16)), 64'(expv));
        @(negedge clk);
        start16 = 1'b1; op16 = op; mode16 = clo;
        @(negedge clk);
        start16 = 1'b0; op16 = 16'($urandom);
        cyc = 1;
        while (!done16 && cyc < 20) begin
            @(negedge clk);
            cyc++;
        end
        check({name, " latency"}, 64'(cyc), 64'(LAT16));
        check({name, " result"}, 64'(res16), 64'(expv));
    endtask

    initial begin
        int          cyc;
        bit          seen;
        logic [15:0] r16;
        logic [31:0] r32;

        rst_n = 1'b0;
        start32 = 1'b0; mode32 = 1'b0; flush32 = 1'b0; op32 = '0;
        start16 = 1'b0; mode16 = 1'b0; flush16 = 1'b0; op16 = '0;
        repeat (3) @(negedge clk);
        check("reset busy32", 64'(busy32), 64'd0);
        check("reset done32", 64'(done32), 64'd0);
        check("reset result32", 64'(res32), 64'd0);
        check("reset busy16", 64'(busy16), 64'd0);
        check("reset result16", 64'(res16), 64'd0);
        rst_n = 1'b1;

        // Basic CLZ with latency, then back-to-back CLZ and CLO cases.
        run32(32'h0001_0000, 1'b0, 15, "clz 00010000");
        run32(32'h8000_0000, 1'b0, 0,  "clz 80000000");
        run32(32'h0000_0001, 1'b0, 31, "clz 00000001");
        run32(32'h0000_0000, 1'b0, 32, "clz 00000000");
        run32(32'h0000_FFFF, 1'b0, 16, "clz 0000ffff");
        run32(32'hFFFF_0000, 1'b1, 16, "clo ffff0000");
        run32(32'hFFFF_FFFF, 1'b1, 32, "clo ffffffff");
        run32(32'h7FFF_FFFF, 1'b1, 0,  "clo 7fffffff");
        run32(32'hFFFF_FFFE, 1'b1, 31, "clo fffffffe");

        // Start while busy must not disturb the in-flight op.
        @(negedge clk); start32 = 1'b1; op32 = 32'h1; mode32 = 1'b0;
        @(negedge clk); start32 = 1'b0; op32 = '0;
        @(negedge clk); start32 = 1'b1; op32 = 32'hFFFF_FFFF;
        @(negedge clk); start32 = 1'b0;
        cyc = 3;
        while (!done32 && cyc < 20) begin
            @(negedge clk);
            cyc++;
        end
        check("ignored start latency", 64'(cyc), 64'(LAT32));
        check("ignored start result", 64'(res32), 64'd31);

        // Flush in cycle 3 of the next op: no done, result held.
        @(negedge clk); start32 = 1'b1; op32 = 32'h0001_0000; mode32 = 1'b0;
        @(negedge clk); start32 = 1'b0;
        @(negedge clk);
        @(negedge clk); flush32 = 1'b1;
        @(negedge clk); flush32 = 1'b0;
        check("flush busy", 64'(busy32), 64'd0);
        check("flush result held", 64'(res32), 64'd31);
        seen = 1'b0;
        repeat (8) begin
            @(negedge clk);
            if (done32) seen = 1'b1;
        end
        check("flush no done", 64'(seen), 64'd0);

        // Asynchronous reset mid-CALC, then a fresh op.
        @(negedge clk); start32 = 1'b1; op32 = 32'h0000_0100; mode32 = 1'b0;
        @(negedge clk); start32 = 1'b0;
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("async rst busy32", 64'(busy32), 64'd0);
        check("async rst done32", 64'(done32), 64'd0);
        check("async rst result32", 64'(res32), 64'd0);
        @(negedge clk);
        #2 rst_n = 1'b1;
        run32(32'h0040_0000, 1'b0, 9, "clz 00400000");

        // 16-bit instance with an 8-bit result.
        run16(16'h0008, 1'b0, 12, "w16 clz 0008");
        run16(16'h0000, 1'b0, 16, "w16 clz 0000");
        run16(16'hC000, 1'b1, 2,  "w16 clo c000");

        // Random operands, modes, stray starts and occasional flushes.
        cyc = 0;
        while (ops16 < 10000 && cyc < 70000) begin
            @(negedge clk);
            r16 = 16'($urandom) >> $urandom_range(0, 16);
            mode16  = 1'($urandom);
            op16    = mode16 ? ~r16 : r16;
            start16 = ($urandom % 16) != 0;
            flush16 = ($urandom % 64) == 0;
            r32 = 32'($urandom) >> $urandom_range(0, 32);
            mode32  = 1'($urandom);
            op32    = mode32 ? ~r32 : r32;
            start32 = ($urandom % 8) != 0;
            flush32 = ($urandom % 64) == 0;
            cyc++;
        end
        @(negedge clk);
        start16 = 1'b0; flush16 = 1'b0; start32 = 1'b0; flush32 = 1'b0;
        repeat (10) @(negedge clk);
        check("random op count reached", 64'(ops16 >= 10000), 64'd1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #900000;
        $display("FAIL watchdog: simulation time limit reached, got timeout, expected completion");
        $fatal(1);
    end

endmodule
